tag_array_ctl: RTL and testbench

Parametrised set-associative tag store with integrated valid bits, lookup compare and a hardware invalidate sweep. It generalises the fixed 4-way x 64-set x 21-bit tag RAM wrapper to configurable ways, sets and tag width. It adds a registered hit/way result, one-hot hit detection with a multi-hit error flag, and a reset/flush init state machine. It sits between a cache pipeline's lookup stage and its refill/eviction logic.

---
 rtl/tag_array_ctl.sv | 157 +++++++++++++++
 tb/tb_tag_array_ctl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tag_array_ctl.sv
// Set-associative tag store with valid bits, registered lookup compare and a
// reset/flush invalidate sweep over every set.
module tag_array_ctl #(
    parameter int unsigned WAYS  = 4,
    parameter int unsigned SETS  = 64,
    parameter int unsigned TAG_W = 21,
    localparam int unsigned IDX_W = $clog2(SETS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    output logic                   init_busy,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [IDX_W-1:0]       req_idx,
    input  logic [TAG_W-1:0]       req_tag,
    input  logic                   wr_valid,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [WAYS-1:0]        wr_way_mask,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic                   wr_vld,
    output logic                   rsp_valid,
    output logic                   rsp_hit,
    output logic [WAYS-1:0]        rsp_hit_way,
    output logic                   rsp_multi_hit,
    output logic [WAYS*TAG_W-1:0]  rsp_tags,
    output logic [WAYS-1:0]        rsp_vld
);

    typedef struct packed {
        logic             vld;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_IDLE = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(SETS - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt, cnt_nxt;

    logic               mem_we;
    logic [IDX_W-1:0]   mem_idx;
    logic [WAYS-1:0]    mem_mask;
    logic [TAG_W-1:0]   mem_tag;
    logic               mem_vld;

    entry_t [WAYS-1:0]  mem [SETS];
    entry_t [WAYS-1:0]  rd_set;
    logic [WAYS-1:0]    hit_vec;
    logic               multi_c;
    logic               req_fire;

    // State and sweep counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, array port arbitration (sweep > write > lookup)
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_busy = 1'b0;
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_idx   = wr_idx;
        mem_mask  = wr_way_mask;
        mem_tag   = wr_tag;
        mem_vld   = wr_vld;
        case (state)
            S_INIT: begin
                init_busy = 1'b1;
                mem_we    = 1'b1;
                mem_idx   = cnt;
                mem_mask  = '1;
                mem_tag   = '0;
                mem_vld   = 1'b0;
                cnt_nxt   = cnt + IDX_W'(1);
                if (flush) begin
                    cnt_nxt = '0;
                end else if (cnt == LAST_SET) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready = !wr_valid;
                mem_we    = wr_valid;
                if (flush) begin
                    state_nxt = S_INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign req_fire = req_valid && req_ready;

    // Tag/valid storage: contents are not reset, only swept
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                if (mem_mask[w]) begin
                    mem[mem_idx][w] <= '{vld: mem_vld, tag: mem_tag};
                end
            end
        end
    end

    assign rd_set = mem[req_idx];

    // Way compare; more than one set bit flags a multi-hit
    always_comb begin
        hit_vec = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            hit_vec[w] = rd_set[w].vld && (rd_set[w].tag == req_tag);
        end
    end

    assign multi_c = |(hit_vec & (hit_vec - WAYS'(1)));

    // Response registers hold their value between accepted lookups
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid     <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_hit_way   <= '0;
            rsp_multi_hit <= 1'b0;
            rsp_tags      <= '0;
            rsp_vld       <= '0;
        end else begin
            rsp_valid <= req_fire;
            if (req_fire) begin
                rsp_hit       <= |hit_vec;
                rsp_hit_way   <= hit_vec;
                rsp_multi_hit <= multi_c;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    rsp_tags[w*TAG_W +: TAG_W] <= rd_set[w].tag;
                    rsp_vld[w]                 <= rd_set[w].vld;
                end
            end
        end
    end

endmodule

// File: tb/tb_tag_array_ctl.sv
// Directed bench for tag_array_ctl: default 4x64x21 instance plus an
// 8-way x 16-set x 30-bit instance sharing clock and reset.
module tb_tag_array_ctl;

    logic        clock;
    logic        reset_n;

    logic        flush, init_busy, req_valid, req_ready;
    logic [5:0]  req_idx, wr_idx;
    logic [20:0] req_tag, wr_tag;
    logic        wr_valid, wr_vld;
    logic [3:0]  wr_way_mask;
    logic        rsp_valid, rsp_hit, rsp_multi_hit;
    logic [3:0]  rsp_hit_way, rsp_vld;
    logic [83:0] rsp_tags;

    logic         b_flush, b_init_busy, b_req_valid, b_req_ready;
    logic [3:0]   b_req_idx, b_wr_idx;
    logic [29:0]  b_req_tag, b_wr_tag;
    logic         b_wr_valid, b_wr_vld;
    logic [7:0]   b_wr_way_mask;
    logic         b_rsp_valid, b_rsp_hit, b_rsp_multi_hit;
    logic [7:0]   b_rsp_hit_way, b_rsp_vld;
    logic [239:0] b_rsp_tags;

    int errors = 0;
    int checks = 0;

    tag_array_ctl u_dut (
        .clock(clock), .reset_n(reset_n), .flush(flush), .init_busy(init_busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_idx(req_idx), .req_tag(req_tag),
        .wr_valid(wr_valid), .wr_idx(wr_idx), .wr_way_mask(wr_way_mask), .wr_tag(wr_tag),
        .wr_vld(wr_vld), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_hit_way(rsp_hit_way),
        .rsp_multi_hit(rsp_multi_hit), .rsp_tags(rsp_tags), .rsp_vld(rsp_vld)
    );

    tag_array_ctl #(.WAYS(8), .SETS(16), .TAG_W(30)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .flush(b_flush), .init_busy(b_init_busy),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_idx(b_req_idx),
        .req_tag(b_req_tag), .wr_valid(b_wr_valid), .wr_idx(b_wr_idx),
        .wr_way_mask(b_wr_way_mask), .wr_tag(b_wr_tag), .wr_vld(b_wr_vld),
        .rsp_valid(b_rsp_valid), .rsp_hit(b_rsp_hit), .rsp_hit_way(b_rsp_hit_way),
        .rsp_multi_hit(b_rsp_multi_hit), .rsp_tags(b_rsp_tags), .rsp_vld(b_rsp_vld)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Counts busy cycles of both instances until idle, bounded
    task automatic wait_init(input int exp_a, input int exp_b);
        int na = 0;
        int nb = 0;
        int n  = 0;
        while ((init_busy || b_init_busy) && n < 1000) begin
            if (init_busy) na++;
            if (b_init_busy) nb++;
            if (req_ready) na += 1000;
            step();
            n++;
        end
        check("init_len_a", 64'(na), 64'(exp_a));
        check("init_len_b", 64'(nb), 64'(exp_b));
    endtask

    task automatic wr_a(input logic [5:0] idx, input logic [3:0] mask,
                        input logic [20:0] tag, input logic vld);
        wr_valid = 1'b1; wr_idx = idx; wr_way_mask = mask; wr_tag = tag; wr_vld = vld;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic rd_a(input logic [5:0] idx, input logic [20:0] tag);
        req_valid = 1'b1; req_idx = idx; req_tag = tag;
        step();
        req_valid = 1'b0;
        check("rsp_valid_a", 64'(rsp_valid), 64'd1);
    endtask

    task automatic wr_b(input logic [3:0] idx, input logic [7:0] mask, input logic [29:0] tag);
        b_wr_valid = 1'b1; b_wr_idx = idx; b_wr_way_mask = mask; b_wr_tag = tag; b_wr_vld = 1'b1;
        step();
        b_wr_valid = 1'b0;
    endtask

    task automatic rd_b(input logic [3:0] idx, input logic [29:0] tag);
        b_req_valid = 1'b1; b_req_idx = idx; b_req_tag = tag;
        step();
        b_req_valid = 1'b0;
        check("rsp_valid_b", 64'(b_rsp_valid), 64'd1);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        flush = 0; req_valid = 0; req_idx = '0; req_tag = '0;
        wr_valid = 0; wr_idx = '0; wr_way_mask = '0; wr_tag = '0; wr_vld = 0;
        b_flush = 0; b_req_valid = 0; b_req_idx = '0; b_req_tag = '0;
        b_wr_valid = 0; b_wr_idx = '0; b_wr_way_mask = '0; b_wr_tag = '0; b_wr_vld = 0;
        #12;
        check("rst_init_busy", 64'(init_busy), 64'd1);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_hit_way", 64'(rsp_hit_way), 64'd0);
        check("rst_rsp_tags", 64'(rsp_tags[63:0]), 64'd0);
        check("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        reset_n = 1'b1;
        wait_init(64, 16);

        rd_a(6'd63, 21'd0);
        check("swept_vld", 64'(rsp_vld), 64'd0);
        check("swept_hit", 64'(rsp_hit), 64'd0);

        // Single-way hit
        wr_a(6'd5, 4'b0100, 21'h1ABCD, 1'b1);
        rd_a(6'd5, 21'h1ABCD);
        check("hit1_hit", 64'(rsp_hit), 64'd1);
        check("hit1_way", 64'(rsp_hit_way), 64'b0100);
        check("hit1_multi", 64'(rsp_multi_hit), 64'd0);
        check("hit1_tag2", 64'(rsp_tags[2*21 +: 21]), 64'h1ABCD);
        check("hit1_vld", 64'(rsp_vld), 64'b0100);
        step();
        check("hold_valid", 64'(rsp_valid), 64'd0);
        check("hold_way", 64'(rsp_hit_way), 64'b0100);

        // Empty mask and unmasked ways leave way 2 intact
        wr_a(6'd5, 4'b0000, 21'h0, 1'b0);
        wr_a(6'd5, 4'b0001, 21'h00005, 1'b1);
        rd_a(6'd5, 21'h1ABCD);
        check("mask_way", 64'(rsp_hit_way), 64'b0100);
        check("mask_tag0", 64'(rsp_tags[20:0]), 64'h5);

        // Multi-hit and miss
        wr_a(6'd9, 4'b1001, 21'h00042, 1'b1);
        rd_a(6'd9, 21'h00042);
        check("multi_way", 64'(rsp_hit_way), 64'b1001);
        check("multi_flag", 64'(rsp_multi_hit), 64'd1);
        check("multi_hit", 64'(rsp_hit), 64'd1);
        rd_a(6'd9, 21'h00043);
        check("miss_hit", 64'(rsp_hit), 64'd0);
        check("miss_multi", 64'(rsp_multi_hit), 64'd0);

        // Write wins over a same-cycle request, request then sees the new tag
        wr_valid = 1; wr_idx = 6'd9; wr_way_mask = 4'b0010; wr_tag = 21'h00077; wr_vld = 1;
        req_valid = 1; req_idx = 6'd9; req_tag = 21'h00077;
        #1;
        check("arb_ready_lo", 64'(req_ready), 64'd0);
        @(posedge clock); #1;
        wr_valid = 0;
        check("arb_no_rsp", 64'(rsp_valid), 64'd0);
        #1;
        check("arb_ready_hi", 64'(req_ready), 64'd1);
        step();
        req_valid = 0;
        check("arb_rsp_valid", 64'(rsp_valid), 64'd1);
        check("arb_way", 64'(rsp_hit_way), 64'b0010);

        // Flush, restarted 10 cycles into the sweep
        flush = 1; step(); flush = 0;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            if (init_busy) n++;
            step();
        end
        flush = 1;
        if (init_busy) n++;
        step();
        flush = 0;
        while (init_busy && n < 1000) begin
            n++;
            step();
        end
        check("flush_len", 64'(n), 64'd74);
        for (int s = 0; s < 64; s++) begin
            rd_a(6'(s), 21'h00042);
            check("flushed_vld", 64'(rsp_vld), 64'd0);
        end

        // Reset in the cycle after acceptance
        wr_a(6'd3, 4'b0001, 21'h00011, 1'b1);
        req_valid = 1; req_idx = 6'd3; req_tag = 21'h00011;
        step();
        req_valid = 0;
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_busy", 64'(init_busy), 64'd1);
        check("mid_rst_way", 64'(rsp_hit_way), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        wait_init(64, 16);
        rd_a(6'd3, 21'h00011);
        check("post_rst_hit", 64'(rsp_hit), 64'd0);

        // Wide instance: single hit and boundary-tag multi-hit
        wr_b(4'd5, 8'b0010_0000, 30'h2ABC_DEF1);
        rd_b(4'd5, 30'h2ABC_DEF1);
        check("b_hit", 64'(b_rsp_hit), 64'd1);
        check("b_way", 64'(b_rsp_hit_way), 64'b0010_0000);
        check("b_multi", 64'(b_rsp_multi_hit), 64'd0);
        check("b_tag5", 64'(b_rsp_tags[5*30 +: 30]), 64'h2ABC_DEF1);
        wr_b(4'd15, 8'b1000_0001, 30'h3FFF_FFFF);
        rd_b(4'd15, 30'h3FFF_FFFF);
        check("b_multi_way", 64'(b_rsp_hit_way), 64'b1000_0001);
        check("b_multi_flag", 64'(b_rsp_multi_hit), 64'd1);
        check("b_tag7", 64'(b_rsp_tags[7*30 +: 30]), 64'h3FFF_FFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
